matrix_mem_arbiter: RTL and testbench
=====================================

# matrix_mem_arbiter

Two-port arbiter that shares the single matrix register-file port (address/type/matrix/read_en/write_en, data/data_ready) between two coprocessor engines, e.g. two matrix-multiply sequencers or one sequencer plus a host load path. Reads are held-request/pulsed-ready. Writes are single-cycle posted pulses, captured in a per-requester one-entry buffer. Arbitration is round-robin, with an optional per-requester lock for atomic read-modify-write sequences such as C += A·B.

## Interface
- size, 4, matrix dimension (row/column cell count)
- cell_width, 16, bits per cell
- address_width, 8, register-file address width
- width, cell_width*size, row/column data bus width
- in_clk  input  1  clock; all state updates on rising edge
- in_reset  input  1  synchronous, active-high reset
- in_r0_address / in_r1_address  input  address_width  requester cell/row/column address
- in_r0_type / in_r1_type  input  2  00 cell, 01 row, 10 column
- in_r0_matrix / in_r1_matrix  input  2  00 A, 01 B, 10 C
- in_r0_read_en / in_r1_read_en  input  1  read request, held until matching data_ready
- in_r0_write_en / in_r1_write_en  input  1  one-cycle write pulse
- in_r0_data / in_r1_data  input  width  write data, valid with write_en
- in_r0_lock / in_r1_lock  input  1  keep ownership across transactions
- out_r0_data / out_r1_data  output  width  read data, valid with data_ready
- out_r0_data_ready / out_r1_data_ready  output  1  one-cycle read-complete pulse
- out_mem_address  output  address_width; out_mem_type  output  2; out_mem_matrix  output  2  forwarded fields
- out_mem_read_en  output  1; out_mem_write_en  output  1; out_mem_data  output  width
- in_mem_data  input  width; in_mem_data_ready  input  1  memory read response
- out_grant  output  2  one-hot current owner, 00 when idle
- out_busy  output  1  state != S_IDLE
- out_overflow  output  1  sticky: write pulse dropped

## Operation
- Write capture: every edge with in_rK_write_en=1 loads wbuf_K (address, type, matrix, data) and sets wpend_K. This happens in any state.
- Overflow: write_en=1 while wpend_K=1 and wbuf_K is not being granted on that edge. The new write is dropped and out_overflow is set.
- Eligibility: requester K is eligible if wpend_K=1 or in_rK_read_en=1. While a lock is held, only the lock owner is eligible.
- Round-robin: pointer rr. If both requesters are eligible, rr wins. After every grant, rr = the other requester.
- Ordering: a requester's own pending write is always served before its own read (RAW safety). No ordering exists across requesters.
- State S_IDLE: out_grant=00. Pick a winner K.
  - If wpend_K: copy wbuf_K to the mem outputs, clear wpend_K, go to S_WRITE. If a capture hits the same edge, the new data reloads wbuf_K, wpend_K stays 1, and no overflow is flagged.
  - Else: latch the live in_rK fields to the mem outputs and go to S_READ.
  - If in_rK_lock=1 on the grant edge, set lock_owner=K.
  - If the owner's lock=0 sampled in S_IDLE, clear the lock before choosing the winner.
- State S_WRITE: out_mem_write_en=1 for exactly one cycle, then S_IDLE.
- State S_READ: out_mem_read_en=1 with fields held stable. On in_mem_data_ready=1: latch in_mem_data into out_rK_data, drop read_en, go to S_DONE.
- State S_DONE: out_rK_data_ready=1 for one cycle, out_rK_data held, then S_IDLE. The requester deasserts read_en on this edge.
- out_rK_data keeps its last value until the next read completion.

## Timing
- Reset: state S_IDLE, rr=r0, lock cleared, wpend cleared, out_overflow cleared. Every output is 0 the cycle after in_reset is sampled high.
- Reset mid-read: out_mem_read_en drops; the read is abandoned with no data_ready; requesters re-request.
- Read latency: read_en first seen in S_IDLE at edge e0. out_mem_read_en is high from e0 until the edge that samples in_mem_data_ready. out_rK_data_ready is high in the following cycle.
- Minimum read is 3 cycles from request to data_ready (memory responds in the first read_en cycle).
- Uncontended write: pulse captured at e0, granted at e1, out_mem_write_en high for cycle e1–e2.
- Transaction spacing: at least one S_IDLE cycle between transactions.
- Fairness: without locks, a requester waits at most one transaction of the other requester.

## Test plan
- Single read: r0 reads row address 4, matrix 00. Memory returns 0xDEAD… 2 cycles after read_en. Expect out_r0_data_ready one pulse carrying that data, out_grant=01 during the transfer, and r1 outputs unchanged.
- Contention: r0 and r1 assert read_en in the same cycle after reset. Expect r0 served first, then r1. Repeated simultaneous requests alternate grants r0, r1, r0.
- Posted write during foreign read: r1 pulses write C[5]=0x0007 while r0's read is in S_READ. Expect out_mem_write_en with address 5, matrix 10, data 0x0007 only after r0's data_ready. out_overflow stays 0.
- RAW ordering: r0 pulses write C[3], then asserts read_en for C[3] on the next cycle. Expect the memory write to C[3] before the memory read of C[3].
- Lock: r0 holds lock=1 through a read of C[2] and a write of C[2] while r1 requests continuously. Expect no r1 grant until r0 lock=0 is sampled in S_IDLE, then r1 is granted next.
- Overflow and reset: r1 pulses two writes while r0 owns a long read. Expect out_overflow=1 and only the first write reaching memory. Assert in_reset mid-read: all outputs are 0 the next cycle and out_overflow is cleared.

Source files
------------

// File: rtl/matrix_mem_arbiter.sv
// Round-robin arbiter sharing one matrix register-file port between two engines.
// Reads are held requests with a pulsed ready; writes are posted into a one-entry buffer per requester.
module matrix_mem_arbiter #(
  parameter int size          = 4,
  parameter int cell_width    = 16,
  parameter int address_width = 8,
  parameter int width         = cell_width * size
) (
  input  logic                     in_clk,
  input  logic                     in_reset,
  input  logic [address_width-1:0] in_r0_address,
  input  logic [1:0]               in_r0_type,
  input  logic [1:0]               in_r0_matrix,
  input  logic                     in_r0_read_en,
  input  logic                     in_r0_write_en,
  input  logic [width-1:0]         in_r0_data,
  input  logic                     in_r0_lock,
  input  logic [address_width-1:0] in_r1_address,
  input  logic [1:0]               in_r1_type,
  input  logic [1:0]               in_r1_matrix,
  input  logic                     in_r1_read_en,
  input  logic                     in_r1_write_en,
  input  logic [width-1:0]         in_r1_data,
  input  logic                     in_r1_lock,
  output logic [width-1:0]         out_r0_data,
  output logic                     out_r0_data_ready,
  output logic [width-1:0]         out_r1_data,
  output logic                     out_r1_data_ready,
  output logic [address_width-1:0] out_mem_address,
  output logic [1:0]               out_mem_type,
  output logic [1:0]               out_mem_matrix,
  output logic                     out_mem_read_en,
  output logic                     out_mem_write_en,
  output logic [width-1:0]         out_mem_data,
  input  logic [width-1:0]         in_mem_data,
  input  logic                     in_mem_data_ready,
  output logic [1:0]               out_grant,
  output logic                     out_busy,
  output logic                     out_overflow
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t state, state_next;

  logic rr;
  logic lock_valid;
  logic lock_owner;
  logic owner;
  logic [1:0] wpend;

  logic [address_width-1:0] wbuf_address [2];
  logic [1:0]               wbuf_type    [2];
  logic [1:0]               wbuf_matrix  [2];
  logic [width-1:0]         wbuf_data    [2];

  logic [address_width-1:0] req_address [2];
  logic [1:0]               req_type    [2];
  logic [1:0]               req_matrix  [2];
  logic [width-1:0]         req_data    [2];
  logic [1:0]               req_read;
  logic [1:0]               req_write;
  logic [1:0]               req_lock;

  logic       lock_keep;
  logic [1:0] elig;
  logic       any_elig;
  logic       winner;
  logic       grant_idle;
  logic [1:0] grant_wr;

  always_comb begin
    req_address[0] = in_r0_address;
    req_address[1] = in_r1_address;
    req_type[0]    = in_r0_type;
    req_type[1]    = in_r1_type;
    req_matrix[0]  = in_r0_matrix;
    req_matrix[1]  = in_r1_matrix;
    req_data[0]    = in_r0_data;
    req_data[1]    = in_r1_data;
    req_read       = {in_r1_read_en, in_r0_read_en};
    req_write      = {in_r1_write_en, in_r0_write_en};
    req_lock       = {in_r1_lock, in_r0_lock};
  end

  // The owner dropping its lock in S_IDLE releases it before this cycle's pick.
  always_comb begin
    lock_keep   = lock_valid && req_lock[lock_owner];
    elig[0]     = (wpend[0] || req_read[0]) && (!lock_keep || !lock_owner);
    elig[1]     = (wpend[1] || req_read[1]) && (!lock_keep || lock_owner);
    any_elig    = |elig;
    winner      = (elig[0] && elig[1]) ? rr : elig[1];
    grant_idle  = (state == S_IDLE) && any_elig;
    grant_wr[0] = grant_idle && !winner && wpend[0];
    grant_wr[1] = grant_idle && winner && wpend[1];
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next        = state;
    out_mem_read_en   = 1'b0;
    out_mem_write_en  = 1'b0;
    out_r0_data_ready = 1'b0;
    out_r1_data_ready = 1'b0;
    out_grant         = 2'b00;
    out_busy          = (state != S_IDLE);
    if (state != S_IDLE) out_grant = owner ? 2'b10 : 2'b01;
    case (state)
      S_IDLE: begin
        if (any_elig) state_next = wpend[winner] ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        out_mem_write_en = 1'b1;
        state_next       = S_IDLE;
      end
      S_READ: begin
        out_mem_read_en = 1'b1;
        if (in_mem_data_ready) state_next = S_DONE;
      end
      S_DONE: begin
        out_r0_data_ready = !owner;
        out_r1_data_ready = owner;
        state_next        = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      rr              <= 1'b0;
      lock_valid      <= 1'b0;
      lock_owner      <= 1'b0;
      owner           <= 1'b0;
      wpend           <= '0;
      out_overflow    <= 1'b0;
      out_mem_address <= '0;
      out_mem_type    <= '0;
      out_mem_matrix  <= '0;
      out_mem_data    <= '0;
      out_r0_data     <= '0;
      out_r1_data     <= '0;
      for (int unsigned k = 0; k < 2; k++) begin
        wbuf_address[k] <= '0;
        wbuf_type[k]    <= '0;
        wbuf_matrix[k]  <= '0;
        wbuf_data[k]    <= '0;
      end
    end else begin
      // A capture on the granting edge refills the buffer being drained, so it is not an overflow.
      for (int unsigned k = 0; k < 2; k++) begin
        if (req_write[k]) begin
          if (wpend[k] && !grant_wr[k]) begin
            out_overflow <= 1'b1;
          end else begin
            wbuf_address[k] <= req_address[k];
            wbuf_type[k]    <= req_type[k];
            wbuf_matrix[k]  <= req_matrix[k];
            wbuf_data[k]    <= req_data[k];
            wpend[k]        <= 1'b1;
          end
        end else if (grant_wr[k]) begin
          wpend[k] <= 1'b0;
        end
      end

      if (state == S_IDLE) begin
        lock_valid <= lock_keep;
        if (any_elig) begin
          owner <= winner;
          rr    <= !winner;
          if (req_lock[winner]) begin
            lock_valid <= 1'b1;
            lock_owner <= winner;
          end
          if (wpend[winner]) begin
            out_mem_address <= wbuf_address[winner];
            out_mem_type    <= wbuf_type[winner];
            out_mem_matrix  <= wbuf_matrix[winner];
            out_mem_data    <= wbuf_data[winner];
          end else begin
            out_mem_address <= req_address[winner];
            out_mem_type    <= req_type[winner];
            out_mem_matrix  <= req_matrix[winner];
            out_mem_data    <= '0;
          end
        end
      end

      if (state == S_READ && in_mem_data_ready) begin
        if (owner) out_r1_data <= in_mem_data;
        else       out_r0_data <= in_mem_data;
      end
    end
  end

endmodule

// File: tb/tb_matrix_mem_arbiter.sv
// Self-checking bench for matrix_mem_arbiter: scoreboards memory-port transactions
// and per-requester read data against a bench-side memory model.
`timescale 1ns/1ps
module tb_matrix_mem_arbiter;

  localparam int AW = 8;
  localparam int W  = 64;

  logic          clk = 1'b0;
  logic          in_reset;
  logic [AW-1:0] in_r0_address, in_r1_address;
  logic [1:0]    in_r0_type, in_r1_type, in_r0_matrix, in_r1_matrix;
  logic          in_r0_read_en, in_r1_read_en, in_r0_write_en, in_r1_write_en;
  logic [W-1:0]  in_r0_data, in_r1_data;
  logic          in_r0_lock, in_r1_lock;
  logic [W-1:0]  out_r0_data, out_r1_data;
  logic          out_r0_data_ready, out_r1_data_ready;
  logic [AW-1:0] out_mem_address;
  logic [1:0]    out_mem_type, out_mem_matrix;
  logic          out_mem_read_en, out_mem_write_en;
  logic [W-1:0]  out_mem_data;
  logic [W-1:0]  in_mem_data;
  logic          in_mem_data_ready;
  logic [1:0]    out_grant;
  logic          out_busy, out_overflow;

  matrix_mem_arbiter #(.size(4), .cell_width(16), .address_width(AW)) dut (
    .in_clk(clk), .in_reset(in_reset),
    .in_r0_address(in_r0_address), .in_r0_type(in_r0_type), .in_r0_matrix(in_r0_matrix),
    .in_r0_read_en(in_r0_read_en), .in_r0_write_en(in_r0_write_en), .in_r0_data(in_r0_data),
    .in_r0_lock(in_r0_lock),
    .in_r1_address(in_r1_address), .in_r1_type(in_r1_type), .in_r1_matrix(in_r1_matrix),
    .in_r1_read_en(in_r1_read_en), .in_r1_write_en(in_r1_write_en), .in_r1_data(in_r1_data),
    .in_r1_lock(in_r1_lock),
    .out_r0_data(out_r0_data), .out_r0_data_ready(out_r0_data_ready),
    .out_r1_data(out_r1_data), .out_r1_data_ready(out_r1_data_ready),
    .out_mem_address(out_mem_address), .out_mem_type(out_mem_type), .out_mem_matrix(out_mem_matrix),
    .out_mem_read_en(out_mem_read_en), .out_mem_write_en(out_mem_write_en), .out_mem_data(out_mem_data),
    .in_mem_data(in_mem_data), .in_mem_data_ready(in_mem_data_ready),
    .out_grant(out_grant), .out_busy(out_busy), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [1:0]    typ;
    logic [1:0]    mat;
    logic [W-1:0]  data;
    logic [1:0]    grant;
  } txn_t;

  txn_t         exp_mem[$];
  logic [W-1:0] exp_r0[$];
  logic [W-1:0] exp_r1[$];
  int total = 0;
  int bad   = 0;
  int mem_lat = 1;

  function automatic logic [W-1:0] mem_word(input logic [AW-1:0] a, input logic [1:0] m);
    return {16'hDEAD, 8'h00, a, 6'b0, m, 8'h00, 16'hBEEF};
  endfunction

  function automatic logic [211:0] all_outs();
    return {out_r0_data, out_r1_data, out_r0_data_ready, out_r1_data_ready, out_mem_address,
            out_mem_type, out_mem_matrix, out_mem_read_en, out_mem_write_en, out_mem_data,
            out_grant, out_busy, out_overflow};
  endfunction

  // Memory model: answers a read mem_lat cycles into out_mem_read_en.
  initial begin : memory
    int cnt;
    cnt = 0;
    in_mem_data = '0;
    in_mem_data_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (out_mem_read_en === 1'b1) begin
        cnt++;
        in_mem_data_ready = (cnt == mem_lat);
        in_mem_data = (cnt == mem_lat) ? mem_word(out_mem_address, out_mem_matrix) : '0;
      end else begin
        cnt = 0;
        in_mem_data_ready = 1'b0;
        in_mem_data = '0;
      end
    end
  end

  initial begin : monitor
    logic prev_rd;
    txn_t t;
    prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (out_mem_write_en === 1'b1 || (out_mem_read_en === 1'b1 && !prev_rd)) begin
        total++;
        if (exp_mem.size() == 0) begin
          bad++;
          $display("FAIL mem_txn unexpected: wr=%0b addr=%0d matrix=%0d grant=%b", out_mem_write_en,
                   out_mem_address, out_mem_matrix, out_grant);
        end else begin
          t = exp_mem.pop_front();
          if ({out_mem_write_en, out_mem_address, out_mem_type, out_mem_matrix, out_grant} !==
              {t.wr, t.addr, t.typ, t.mat, t.grant} || (t.wr && out_mem_data !== t.data)) begin
            bad++;
            $display("FAIL mem_txn: got wr=%0b addr=%0d type=%0d matrix=%0d data=%h grant=%b, want wr=%0b addr=%0d type=%0d matrix=%0d data=%h grant=%b",
                     out_mem_write_en, out_mem_address, out_mem_type, out_mem_matrix, out_mem_data, out_grant,
                     t.wr, t.addr, t.typ, t.mat, t.data, t.grant);
          end
        end
      end
      if (out_r0_data_ready === 1'b1) begin
        total++;
        if (exp_r0.size() == 0) begin
          bad++;
          $display("FAIL r0_data unexpected ready: data=%h", out_r0_data);
        end else if (out_r0_data !== exp_r0[0]) begin
          bad++;
          $display("FAIL r0_data: got %h want %h", out_r0_data, exp_r0[0]);
        end
        if (exp_r0.size() != 0) void'(exp_r0.pop_front());
      end
      if (out_r1_data_ready === 1'b1) begin
        total++;
        if (exp_r1.size() == 0) begin
          bad++;
          $display("FAIL r1_data unexpected ready: data=%h", out_r1_data);
        end else if (out_r1_data !== exp_r1[0]) begin
          bad++;
          $display("FAIL r1_data: got %h want %h", out_r1_data, exp_r1[0]);
        end
        if (exp_r1.size() != 0) void'(exp_r1.pop_front());
      end
      prev_rd = (out_mem_read_en === 1'b1);
    end
  end

  initial begin : watchdog
    #300000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic clear_inputs();
    in_r0_address = '0; in_r0_type = '0; in_r0_matrix = '0; in_r0_read_en = 0;
    in_r0_write_en = 0; in_r0_data = '0; in_r0_lock = 0;
    in_r1_address = '0; in_r1_type = '0; in_r1_matrix = '0; in_r1_read_en = 0;
    in_r1_write_en = 0; in_r1_data = '0; in_r1_lock = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_reset = 1;
    clear_inputs();
    @(negedge clk);
    in_reset = 0;
    exp_mem.delete();
    exp_r0.delete();
    exp_r1.delete();
  endtask

  // Steps cycles, dropping each read_en once its data_ready is seen.
  task automatic wait_reads(input int budget, output bit done);
    int cycles;
    cycles = 0;
    done = 0;
    while (cycles < budget && !done) begin
      @(negedge clk);
      cycles++;
      if (out_r0_data_ready === 1'b1) in_r0_read_en = 0;
      if (out_r1_data_ready === 1'b1) in_r1_read_en = 0;
      done = !in_r0_read_en && !in_r1_read_en;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    in_reset = 1;
    clear_inputs();
    @(negedge clk);
    total++;
    if (all_outs() !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", all_outs());
    end
    in_reset = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({out_grant, out_busy, out_mem_read_en, out_mem_write_en} !== 5'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got %b want 00000", {out_grant, out_busy, out_mem_read_en, out_mem_write_en});
    end
  endtask

  task automatic test_single_read();
    int lat_seen;
    do_reset();
    mem_lat = 2;
    in_r0_address = 8'd4; in_r0_type = 2'b01; in_r0_matrix = 2'b00; in_r0_read_en = 1;
    exp_mem.push_back('{1'b0, 8'd4, 2'b01, 2'b00, 64'h0, 2'b01});
    exp_r0.push_back(mem_word(8'd4, 2'b00));
    lat_seen = 0;
    for (int i = 1; i <= 20 && lat_seen == 0; i++) begin
      @(negedge clk);
      if (out_r0_data_ready === 1'b1) begin
        lat_seen = i;
        in_r0_read_en = 0;
      end
    end
    total++;
    if (lat_seen != 3) begin
      bad++;
      $display("FAIL single_read_latency: got %0d cycles want 3", lat_seen);
    end
    @(negedge clk);
    total++;
    if ({out_r0_data_ready, out_r0_data} !== {1'b0, mem_word(8'd4, 2'b00)}) begin
      bad++;
      $display("FAIL single_read_hold: got ready=%0b data=%h want ready=0 data=%h", out_r0_data_ready,
               out_r0_data, mem_word(8'd4, 2'b00));
    end
    total++;
    if (out_r1_data !== '0) begin
      bad++;
      $display("FAIL single_read_r1_untouched: got %h want 0", out_r1_data);
    end
    total++;
    if (exp_mem.size() != 0 || exp_r0.size() != 0) begin
      bad++;
      $display("FAIL single_read_drain: got %0d/%0d outstanding want 0/0", exp_mem.size(), exp_r0.size());
    end
  endtask

  task automatic test_contention();
    bit done;
    do_reset();
    mem_lat = 1;
    for (int r = 0; r < 2; r++) begin
      in_r0_address = 8'(10 + r); in_r0_type = 2'b00; in_r0_matrix = 2'b00; in_r0_read_en = 1;
      in_r1_address = 8'(20 + r); in_r1_type = 2'b00; in_r1_matrix = 2'b01; in_r1_read_en = 1;
      exp_mem.push_back('{1'b0, 8'(10 + r), 2'b00, 2'b00, 64'h0, 2'b01});
      exp_mem.push_back('{1'b0, 8'(20 + r), 2'b00, 2'b01, 64'h0, 2'b10});
      exp_r0.push_back(mem_word(8'(10 + r), 2'b00));
      exp_r1.push_back(mem_word(8'(20 + r), 2'b01));
      wait_reads(40, done);
      total++;
      if (!done) begin
        bad++;
        $display("FAIL contention_round%0d: reads still pending after 40 cycles, want done", r);
      end
    end
    total++;
    if (exp_mem.size() + exp_r0.size() + exp_r1.size() != 0) begin
      bad++;
      $display("FAIL contention_drain: got %0d outstanding want 0", exp_mem.size() + exp_r0.size() + exp_r1.size());
    end
  endtask

  task automatic test_posted_write();
    bit seen_ready, early, wrote;
    do_reset();
    mem_lat = 6;
    in_r0_address = 8'd1; in_r0_type = 2'b00; in_r0_matrix = 2'b00; in_r0_read_en = 1;
    exp_mem.push_back('{1'b0, 8'd1, 2'b00, 2'b00, 64'h0, 2'b01});
    exp_r0.push_back(mem_word(8'd1, 2'b00));
    repeat (2) @(negedge clk);
    in_r1_address = 8'd5; in_r1_type = 2'b00; in_r1_matrix = 2'b10; in_r1_data = 64'h7; in_r1_write_en = 1;
    exp_mem.push_back('{1'b1, 8'd5, 2'b00, 2'b10, 64'h7, 2'b10});
    @(negedge clk);
    in_r1_write_en = 0;
    seen_ready = 0; early = 0; wrote = 0;
    for (int i = 0; i < 30 && !wrote; i++) begin
      @(negedge clk);
      if (out_r0_data_ready === 1'b1) begin
        seen_ready = 1;
        in_r0_read_en = 0;
      end
      if (out_mem_write_en === 1'b1) begin
        wrote = 1;
        if (!seen_ready) early = 1;
      end
    end
    total++;
    if ({wrote, early} !== 2'b10) begin
      bad++;
      $display("FAIL posted_write_order: got wrote=%0b early=%0b want wrote=1 early=0", wrote, early);
    end
    total++;
    if (out_overflow !== 1'b0) begin
      bad++;
      $display("FAIL posted_write_overflow: got %0b want 0", out_overflow);
    end
  endtask

  task automatic test_raw();
    bit done;
    do_reset();
    mem_lat = 1;
    in_r0_address = 8'd3; in_r0_type = 2'b00; in_r0_matrix = 2'b10;
    in_r0_data = 64'h1234_5678_9ABC_DEF0; in_r0_write_en = 1;
    exp_mem.push_back('{1'b1, 8'd3, 2'b00, 2'b10, 64'h1234_5678_9ABC_DEF0, 2'b01});
    @(negedge clk);
    in_r0_write_en = 0;
    in_r0_read_en = 1;
    exp_mem.push_back('{1'b0, 8'd3, 2'b00, 2'b10, 64'h0, 2'b01});
    exp_r0.push_back(mem_word(8'd3, 2'b10));
    wait_reads(30, done);
    total++;
    if (!done || exp_mem.size() != 0) begin
      bad++;
      $display("FAIL raw_order: got done=%0b outstanding=%0d want done=1 outstanding=0", done, exp_mem.size());
    end
  endtask

  task automatic test_lock();
    bit done, got_ready, got_write;
    do_reset();
    mem_lat = 2;
    in_r0_lock = 1;
    in_r0_address = 8'd2; in_r0_type = 2'b00; in_r0_matrix = 2'b10; in_r0_read_en = 1;
    exp_mem.push_back('{1'b0, 8'd2, 2'b00, 2'b10, 64'h0, 2'b01});
    exp_mem.push_back('{1'b1, 8'd2, 2'b00, 2'b10, 64'hC0FFEE, 2'b01});
    exp_r0.push_back(mem_word(8'd2, 2'b10));
    @(negedge clk);
    in_r1_address = 8'd9; in_r1_type = 2'b01; in_r1_matrix = 2'b01; in_r1_read_en = 1;
    exp_mem.push_back('{1'b0, 8'd9, 2'b01, 2'b01, 64'h0, 2'b10});
    exp_r1.push_back(mem_word(8'd9, 2'b01));
    got_ready = 0;
    for (int i = 0; i < 20 && !got_ready; i++) begin
      @(negedge clk);
      if (out_r0_data_ready === 1'b1) got_ready = 1;
    end
    in_r0_read_en = 0;
    in_r0_data = 64'hC0FFEE; in_r0_write_en = 1;
    @(negedge clk);
    in_r0_write_en = 0;
    got_write = 0;
    for (int i = 0; i < 10 && !got_write; i++) begin
      if (out_mem_write_en === 1'b1) got_write = 1;
      else @(negedge clk);
    end
    repeat (3) @(negedge clk);
    total++;
    if ({got_ready, got_write, out_grant} !== 4'b1100) begin
      bad++;
      $display("FAIL lock_hold: got ready=%0b write=%0b grant=%b want ready=1 write=1 grant=00",
               got_ready, got_write, out_grant);
    end
    in_r0_lock = 0;
    @(negedge clk);
    total++;
    if (out_grant !== 2'b10) begin
      bad++;
      $display("FAIL lock_release_grant: got %b want 10", out_grant);
    end
    wait_reads(20, done);
    total++;
    if (!done || exp_mem.size() + exp_r1.size() != 0) begin
      bad++;
      $display("FAIL lock_drain: got done=%0b outstanding=%0d want done=1 outstanding=0", done,
               exp_mem.size() + exp_r1.size());
    end
  endtask

  task automatic test_overflow_reset();
    bit done;
    do_reset();
    mem_lat = 8;
    in_r0_address = 8'd6; in_r0_type = 2'b00; in_r0_matrix = 2'b00; in_r0_read_en = 1;
    exp_mem.push_back('{1'b0, 8'd6, 2'b00, 2'b00, 64'h0, 2'b01});
    exp_r0.push_back(mem_word(8'd6, 2'b00));
    repeat (2) @(negedge clk);
    in_r1_address = 8'd7; in_r1_type = 2'b00; in_r1_matrix = 2'b10; in_r1_data = 64'h11; in_r1_write_en = 1;
    exp_mem.push_back('{1'b1, 8'd7, 2'b00, 2'b10, 64'h11, 2'b10});
    @(negedge clk);
    in_r1_data = 64'h22;
    @(negedge clk);
    in_r1_write_en = 0;
    total++;
    if (out_overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_set: got %0b want 1", out_overflow);
    end
    wait_reads(40, done);
    repeat (4) @(negedge clk);
    total++;
    if (!done || exp_mem.size() != 0 || out_overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_drain: got done=%0b outstanding=%0d overflow=%0b want 1/0/1", done,
               exp_mem.size(), out_overflow);
    end
    mem_lat = 30;
    in_r0_address = 8'd8; in_r0_read_en = 1;
    exp_mem.push_back('{1'b0, 8'd8, 2'b00, 2'b00, 64'h0, 2'b01});
    repeat (3) @(negedge clk);
    in_reset = 1;
    in_r0_read_en = 0;
    @(negedge clk);
    total++;
    if (all_outs() !== '0) begin
      bad++;
      $display("FAIL reset_mid_read: got %h want 0", all_outs());
    end
    in_reset = 0;
    repeat (5) @(negedge clk);
    total++;
    if (exp_mem.size() != 0 || out_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_abandon: got outstanding=%0d busy=%0b want 0/0", exp_mem.size(), out_busy);
    end
  endtask

  initial begin
    in_reset = 1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_posted_write();
    test_raw();
    test_lock();
    test_overflow_reset();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
